// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline ports,
// the port arbiter and the shared unified memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ready;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall_if;
   logic              stall_mem;

   modport master (
      output if_req, if_addr,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_rdata, if_ready,
      input  dm_rdata, dm_ready,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  stall_if, stall_mem
   );

   modport slave (
      input  if_req, if_addr,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_rdata, if_ready,
      output dm_rdata, dm_ready,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output stall_if, stall_mem
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between IF and MEM stages.
// Data port preferred; alternates under contention.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input logic             clk,
   input logic             rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sel_q, sel_d;
   logic              last_dm_q, last_dm_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              gnt_dm;
   logic              if_rdy;
   logic              dm_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sel_q      <= 1'b0;
         last_dm_q  <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         last_dm_q  <= last_dm_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   // sel_q = 1 means the data port owns the access
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      last_dm_d  = last_dm_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      gnt_dm     = bus.dm_req & (~bus.if_req | ~last_dm_q);
      unique case (state_q)
         IDLE: begin
            if (bus.if_req | bus.dm_req) begin
               state_d   = BUSY;
               cnt_d     = '0;
               sel_d     = gnt_dm;
               last_dm_d = gnt_dm;
               we_d      = gnt_dm & bus.dm_we;
               addr_d    = gnt_dm ? bus.dm_addr : bus.if_addr;
               wdata_d   = gnt_dm ? bus.dm_wdata : '0;
            end
         end
         BUSY: begin
            if (cnt_q == CNT_LAST) begin
               state_d = RESP;
               if (!we_q) begin
                  if (sel_q) dm_rdata_d = bus.mem_rdata;
                  else       if_rdata_d = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      if_rdy        = (state_q == RESP) & ~sel_q;
      dm_rdy        = (state_q == RESP) & sel_q;
      bus.mem_en    = (state_q == BUSY);
      bus.mem_we    = (state_q == BUSY) & we_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.if_ready  = if_rdy;
      bus.dm_ready  = dm_rdy;
      bus.if_rdata  = if_rdata_q;
      bus.dm_rdata  = dm_rdata_q;
      bus.stall_if  = bus.if_req & ~if_rdy;
      bus.stall_mem = bus.dm_req & ~dm_rdy;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-timeline model.
module tb_mem_port_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 2;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [DW-1:0] emem [logic [AW-1:0]];
   logic [DW-1:0] rmem [logic [AW-1:0]];

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return a ^ 32'hC3C3_5A5A;
   endfunction

   function automatic logic [DW-1:0] rref(input logic [AW-1:0] a);
      return rmem.exists(a) ? rmem[a] : dflt(a);
   endfunction

   function automatic logic [AW-1:0] raddr();
      return AW'($urandom_range(15)) << 2;
   endfunction

   task automatic idle();
      bus.if_req     = 1'b0;
      bus.if_addr    = '0;
      bus.dm_req     = 1'b0;
      bus.dm_we      = 1'b0;
      bus.dm_addr    = '0;
      bus.dm_wdata   = '0;
      bus.mem_rdata  = '0;
      bus1.if_req    = 1'b0;
      bus1.if_addr   = '0;
      bus1.dm_req    = 1'b0;
      bus1.dm_we     = 1'b0;
      bus1.dm_addr   = '0;
      bus1.dm_wdata  = '0;
      bus1.mem_rdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // memory emulation: writes land, reads return stored/default
   task automatic tick();
      @(negedge clk);
      if (bus.mem_en && bus.mem_we)
         emem[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata = emem.exists(bus.mem_addr) ?
                      emem[bus.mem_addr] : dflt(bus.mem_addr);
   endtask

   task automatic test_reset();
      logic [131:0] g;
      rst_n = 1'b0;
      idle();
      bus.if_req = 1'b1;
      repeat (2) @(negedge clk);
      g = {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
           bus.if_rdata, bus.dm_rdata, bus.if_ready, bus.dm_ready};
      total++;
      if (g !== '0) begin
         bad++;
         $display("FAIL reset_outs got=%h exp=0", g);
      end
      total++;
      if (bus.stall_if !== 1'b1) begin
         bad++;
         $display("FAIL reset_stall got=%b exp=1", bus.stall_if);
      end
      g = {bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata,
           bus1.if_rdata, bus1.dm_rdata, bus1.if_ready, bus1.dm_ready};
      total++;
      if (g !== '0) begin
         bad++;
         $display("FAIL reset_outs1 got=%h exp=0", g);
      end
      idle();
   endtask

   task automatic test_if_read();
      logic [3:0] e;
      logic [3:0] g;
      idle();
      do_reset();
      emem[32'h40] = 32'h2002_0004;
      bus.if_addr = 32'h40;
      bus.if_req  = 1'b1;
      #1;
      total++;
      if (bus.stall_if !== 1'b1) begin
         bad++;
         $display("FAIL ifrd_stall0 got=%b exp=1", bus.stall_if);
      end
      for (int c = 1; c <= 5; c++) begin
         tick();
         e = {(c == 1 || c == 2), 1'b0, (c == 3), 1'b0};
         g = {bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL ifrd_ctl c=%0d got=%b exp=%b", c, g, e);
         end
         if (c <= 2) begin
            total++;
            if (bus.mem_addr !== 32'h40) begin
               bad++;
               $display("FAIL ifrd_addr c=%0d got=%h exp=40",
                        c, bus.mem_addr);
            end
         end
         total++;
         if (bus.stall_if !== (c <= 2)) begin
            bad++;
            $display("FAIL ifrd_stall c=%0d got=%b exp=%b",
                     c, bus.stall_if, (c <= 2));
         end
         if (c == 3) begin
            total++;
            if (bus.if_rdata !== 32'h2002_0004) begin
               bad++;
               $display("FAIL ifrd_data got=%h exp=20020004",
                        bus.if_rdata);
            end
            bus.if_req = 1'b0;
         end
      end
   endtask

   task automatic test_dm_write();
      logic [3:0] e;
      logic [3:0] g;
      idle();
      do_reset();
      emem[32'h100] = 32'h1111_2222;
      bus.dm_addr = 32'h100;
      bus.dm_req  = 1'b1;
      repeat (3) tick();
      total++;
      if ({bus.dm_ready, bus.dm_rdata} !== {1'b1, 32'h1111_2222}) begin
         bad++;
         $display("FAIL dmwr_preread got=%b/%h exp=1/11112222",
                  bus.dm_ready, bus.dm_rdata);
      end
      bus.dm_we    = 1'b1;
      bus.dm_wdata = 32'hDEAD_BEEF;
      tick();
      for (int c = 5; c <= 8; c++) begin
         tick();
         e = {(c == 5 || c == 6), (c == 5 || c == 6), 1'b0, (c == 7)};
         g = {bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL dmwr_ctl c=%0d got=%b exp=%b", c, g, e);
         end
         if (c <= 6) begin
            total++;
            if ({bus.mem_addr, bus.mem_wdata} !==
                {32'h100, 32'hDEAD_BEEF}) begin
               bad++;
               $display("FAIL dmwr_bus c=%0d got=%h/%h exp=100/deadbeef",
                        c, bus.mem_addr, bus.mem_wdata);
            end
         end
         total++;
         if (bus.dm_rdata !== 32'h1111_2222) begin
            bad++;
            $display("FAIL dmwr_rdata c=%0d got=%h exp=11112222",
                     c, bus.dm_rdata);
         end
         if (c == 7) bus.dm_req = 1'b0;
      end
   endtask

   task automatic test_contend();
      logic [1:0]    e;
      logic          en;
      logic [AW-1:0] ea;
      idle();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h300;
      bus.dm_req  = 1'b1;
      bus.dm_addr = 32'h200;
      do_reset();
      for (int c = 1; c <= 16; c++) begin
         tick();
         e  = {(c == 7 || c == 15), (c == 3 || c == 11)};
         en = (c % 4 == 1) || (c % 4 == 2);
         ea = ((c / 4) % 2 == 0) ? 32'h200 : 32'h300;
         total++;
         if ({bus.if_ready, bus.dm_ready} !== e) begin
            bad++;
            $display("FAIL contend_rdy c=%0d got=%b%b exp=%b",
                     c, bus.if_ready, bus.dm_ready, e);
         end
         total++;
         if (bus.mem_en !== en) begin
            bad++;
            $display("FAIL contend_en c=%0d got=%b exp=%b",
                     c, bus.mem_en, en);
         end
         if (en) begin
            total++;
            if (bus.mem_addr !== ea) begin
               bad++;
               $display("FAIL contend_addr c=%0d got=%h exp=%h",
                        c, bus.mem_addr, ea);
            end
         end
      end
      idle();
   endtask

   task automatic test_drop();
      logic [3:0] e;
      logic [3:0] g;
      idle();
      do_reset();
      emem.delete(32'h80);
      bus.dm_addr = 32'h80;
      bus.dm_req  = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         e = {(c == 1 || c == 2), 1'b0, 1'b0, (c == 3)};
         g = {bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL drop_ctl c=%0d got=%b exp=%b", c, g, e);
         end
         total++;
         if (bus.stall_mem !== (c == 1)) begin
            bad++;
            $display("FAIL drop_stall c=%0d got=%b exp=%b",
                     c, bus.stall_mem, (c == 1));
         end
         if (c == 3) begin
            total++;
            if (bus.dm_rdata !== dflt(32'h80)) begin
               bad++;
               $display("FAIL drop_data got=%h exp=%h",
                        bus.dm_rdata, dflt(32'h80));
            end
         end
         if (c == 1) bus.dm_req = 1'b0;
      end
   endtask

   task automatic test_reset_busy();
      logic [131:0] g;
      logic [3:0]   e;
      logic [3:0]   v;
      idle();
      do_reset();
      emem.delete(32'h44);
      bus.if_addr = 32'h44;
      bus.if_req  = 1'b1;
      tick();
      total++;
      if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'h44}) begin
         bad++;
         $display("FAIL rbusy_pre got=%b/%h exp=1/44",
                  bus.mem_en, bus.mem_addr);
      end
      rst_n = 1'b0;
      #1;
      g = {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
           bus.if_rdata, bus.dm_rdata, bus.if_ready, bus.dm_ready};
      total++;
      if (g !== '0) begin
         bad++;
         $display("FAIL rbusy_zero got=%h exp=0", g);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         total++;
         if ({bus.if_ready, bus.mem_en} !== 2'b00) begin
            bad++;
            $display("FAIL rbusy_hold k=%0d got=%b%b exp=00",
                     k, bus.if_ready, bus.mem_en);
         end
      end
      rst_n = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         e = {(c == 1 || c == 2), 1'b0, (c == 3), 1'b0};
         v = {bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready};
         total++;
         if (v !== e) begin
            bad++;
            $display("FAIL rbusy_ctl c=%0d got=%b exp=%b", c, v, e);
         end
         if (c == 3) begin
            total++;
            if (bus.if_rdata !== dflt(32'h44)) begin
               bad++;
               $display("FAIL rbusy_data got=%h exp=%h",
                        bus.if_rdata, dflt(32'h44));
            end
            bus.if_req = 1'b0;
         end
      end
   endtask

   // timeline model: grant at cycle g, access g+1..g+LAT,
   // ready at g+LAT+1, next grant no earlier than g+LAT+2
   task automatic test_random();
      int            g;
      bit            t_dm;
      bit            t_we;
      bit            last_dm;
      bit            en;
      bit            rdy;
      logic [AW-1:0] t_a;
      logic [DW-1:0] t_d;
      logic [DW-1:0] e_if;
      logic [DW-1:0] e_dm;
      logic [3:0]    e;
      logic [3:0]    v;
      logic [1:0]    es;
      g = -100;
      t_dm = 1'b0;
      t_we = 1'b0;
      last_dm = 1'b0;
      t_a = '0;
      t_d = '0;
      e_if = '0;
      e_dm = '0;
      idle();
      do_reset();
      emem.delete();
      rmem.delete();
      for (int c = 0; c < 600; c++) begin
         tick();
         en  = (c >= g + 1) && (c <= g + LAT);
         rdy = (c == g + LAT + 1);
         if (rdy && !t_we) begin
            if (t_dm) e_dm = rref(t_a);
            else      e_if = rref(t_a);
         end
         if (rdy && t_we) rmem[t_a] = t_d;
         e = {en, en & t_we, rdy & ~t_dm, rdy & t_dm};
         v = {bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready};
         total++;
         if (v !== e) begin
            bad++;
            $display("FAIL rnd_ctl c=%0d got=%b exp=%b", c, v, e);
         end
         if (en) begin
            total++;
            if (bus.mem_addr !== t_a) begin
               bad++;
               $display("FAIL rnd_addr c=%0d got=%h exp=%h",
                        c, bus.mem_addr, t_a);
            end
         end
         if (en && t_we) begin
            total++;
            if (bus.mem_wdata !== t_d) begin
               bad++;
               $display("FAIL rnd_wdata c=%0d got=%h exp=%h",
                        c, bus.mem_wdata, t_d);
            end
         end
         total++;
         if ({bus.if_rdata, bus.dm_rdata} !== {e_if, e_dm}) begin
            bad++;
            $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h/%h",
                     c, bus.if_rdata, bus.dm_rdata, e_if, e_dm);
         end
         es = {bus.if_req & ~(rdy & ~t_dm), bus.dm_req & ~(rdy & t_dm)};
         total++;
         if ({bus.stall_if, bus.stall_mem} !== es) begin
            bad++;
            $display("FAIL rnd_stall c=%0d got=%b%b exp=%b",
                     c, bus.stall_if, bus.stall_mem, es);
         end
         if (!t_dm && c > g && c < g + LAT + 1) begin
            if ($urandom_range(3) == 0) bus.if_req = 1'b0;
         end else if (!t_dm && c == g + LAT + 1) begin
            bus.if_req  = 1'($urandom_range(1));
            bus.if_addr = raddr();
         end else if (!bus.if_req && $urandom_range(2) == 0) begin
            bus.if_req  = 1'b1;
            bus.if_addr = raddr();
         end
         if (t_dm && c > g && c < g + LAT + 1) begin
            if ($urandom_range(3) == 0) bus.dm_req = 1'b0;
         end else if ((t_dm && c == g + LAT + 1) ||
                      (!bus.dm_req && $urandom_range(2) == 0)) begin
            bus.dm_req   = (t_dm && c == g + LAT + 1) ?
                           1'($urandom_range(1)) : 1'b1;
            bus.dm_we    = 1'($urandom_range(1));
            bus.dm_addr  = raddr();
            bus.dm_wdata = $urandom;
         end
         if (c >= g + LAT + 2 && (bus.if_req || bus.dm_req)) begin
            t_dm    = bus.dm_req && (!bus.if_req || !last_dm);
            last_dm = t_dm;
            g       = c;
            t_we    = t_dm && bus.dm_we;
            t_a     = t_dm ? bus.dm_addr : bus.if_addr;
            t_d     = bus.dm_wdata;
         end
      end
      idle();
   endtask

   task automatic test_lat1();
      logic [DW-1:0] cap;
      logic [3:0]    e;
      logic [3:0]    v;
      cap = '0;
      idle();
      do_reset();
      bus1.dm_addr = raddr();
      bus1.dm_req  = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         bus1.mem_rdata = $urandom;
         e = {(c % 3 == 1), 1'b0, 1'b0, (c % 3 == 2)};
         v = {bus1.mem_en, bus1.mem_we, bus1.if_ready, bus1.dm_ready};
         total++;
         if (v !== e) begin
            bad++;
            $display("FAIL lat1_ctl c=%0d got=%b exp=%b", c, v, e);
         end
         if (c % 3 == 1) begin
            cap = bus1.mem_rdata;
            total++;
            if (bus1.mem_addr !== bus1.dm_addr) begin
               bad++;
               $display("FAIL lat1_addr c=%0d got=%h exp=%h",
                        c, bus1.mem_addr, bus1.dm_addr);
            end
         end
         if (c % 3 == 2) begin
            total++;
            if (bus1.dm_rdata !== cap) begin
               bad++;
               $display("FAIL lat1_data c=%0d got=%h exp=%h",
                        c, bus1.dm_rdata, cap);
            end
            bus1.dm_addr = raddr();
         end
      end
      idle();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle();
      test_reset();
      test_if_read();
      test_dm_write();
      test_contend();
      test_drop();
      test_reset_busy();
      test_random();
      test_lat1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
